// File: rtl/crg_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : crg_rst_sequencer
// Description : Releases peripheral reset domains one at a time, in index
//               order and with programmable spacing, once the platform is
//               ready. Afterwards it services per-domain soft-reset requests
//               by holding one domain in reset for a fixed time and then
//               acknowledging. Every output comes straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module crg_rst_sequencer #(
    parameter int NUM_DOM     = 4,   // number of sequenced reset domains
    parameter int GAP_CYCLES  = 16,  // spacing between start-up releases (>= 1)
    parameter int HOLD_CYCLES = 32,  // soft-reset hold time (>= 1)
    parameter int CNT_W       = 8    // 2**CNT_W > max(GAP_CYCLES, HOLD_CYCLES)
) (
    input  logic               sys_clk,
    input  logic               sys_rstn,
    input  logic               init_done,
    input  logic [NUM_DOM-1:0] soft_req,
    output logic [NUM_DOM-1:0] dom_rstn,
    output logic [NUM_DOM-1:0] soft_ack,
    output logic               seq_busy,
    output logic               all_ready
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_GAP       = 2'd1,
        ST_RUN       = 2'd2,
        ST_SOFT      = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   counter_q,   counter_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [NUM_DOM-1:0] pending_q,   pending_d;
    logic [NUM_DOM-1:0] dom_rstn_q,  dom_rstn_d;
    logic [NUM_DOM-1:0] soft_ack_q,  soft_ack_d;
    logic               seq_busy_q,  seq_busy_d;
    logic               all_ready_q, all_ready_d;

    logic [IDX_W-1:0]   sel_idx;

    // Fixed-priority pick of the lowest pending domain.
    always_comb begin
        sel_idx = '0;
        for (int k = NUM_DOM - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                sel_idx = IDX_W'(k);
            end
        end
    end

    // Next-state, counter, pending and registered-output computation.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        dom_rstn_d  = dom_rstn_q;
        soft_ack_d  = '0;
        seq_busy_d  = seq_busy_q;
        all_ready_d = all_ready_q;

        case (state_q)
            ST_WAIT_INIT: begin
                if (init_done) begin
                    state_d   = ST_GAP;
                    idx_d     = '0;
                    counter_d = '0;
                end
            end

            ST_GAP: begin
                if (counter_q == GAP_LAST) begin
                    dom_rstn_d[idx_q] = 1'b1;
                    counter_d         = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d     = ST_RUN;
                        seq_busy_d  = 1'b0;
                        all_ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (|pending_q) begin
                    state_d             = ST_SOFT;
                    idx_d               = sel_idx;
                    dom_rstn_d[sel_idx] = 1'b0;
                    pending_d[sel_idx]  = 1'b0;
                    counter_d           = '0;
                    seq_busy_d          = 1'b1;
                    all_ready_d         = 1'b0;
                end
                // A new request beats a clear of the same bit.
                pending_d = pending_d | soft_req;
            end

            ST_SOFT: begin
                pending_d = pending_q | soft_req;
                if (counter_q == HOLD_LAST) begin
                    dom_rstn_d[idx_q] = 1'b1;
                    soft_ack_d[idx_q] = 1'b1;
                    state_d           = ST_RUN;
                    counter_d         = '0;
                    // Stay busy across the single RUN cycle if more work waits.
                    seq_busy_d        = |pending_d;
                    all_ready_d       = ~(|pending_d);
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_WAIT_INIT;
            end
        endcase

        // Losing platform readiness puts every domain back in reset and drops
        // any soft reset in progress without acknowledging it.
        if (state_q != ST_WAIT_INIT && !init_done) begin
            state_d     = ST_WAIT_INIT;
            counter_d   = '0;
            idx_d       = '0;
            pending_d   = '0;
            dom_rstn_d  = '0;
            soft_ack_d  = '0;
            seq_busy_d  = 1'b1;
            all_ready_d = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q     <= ST_WAIT_INIT;
            counter_q   <= '0;
            idx_q       <= '0;
            pending_q   <= '0;
            dom_rstn_q  <= '0;
            soft_ack_q  <= '0;
            seq_busy_q  <= 1'b1;
            all_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            dom_rstn_q  <= dom_rstn_d;
            soft_ack_q  <= soft_ack_d;
            seq_busy_q  <= seq_busy_d;
            all_ready_q <= all_ready_d;
        end
    end

    assign dom_rstn  = dom_rstn_q;
    assign soft_ack  = soft_ack_q;
    assign seq_busy  = seq_busy_q;
    assign all_ready = all_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_crg_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_crg_rst_sequencer
// Description : Directed bench for crg_rst_sequencer. Stimulus pushes the
//               expected output changes (edge number and full output word)
//               into a scoreboard queue; a monitor pops and compares each
//               time the DUT outputs change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crg_rst_sequencer;

    localparam int NUM_DOM = 4;

    logic               sys_clk;
    logic               sys_rstn;
    logic               init_done;
    logic [NUM_DOM-1:0] soft_req;
    logic [NUM_DOM-1:0] dom_rstn;
    logic [NUM_DOM-1:0] soft_ack;
    logic               seq_busy;
    logic               all_ready;

    crg_rst_sequencer #(
        .NUM_DOM     (NUM_DOM),
        .GAP_CYCLES  (16),
        .HOLD_CYCLES (32),
        .CNT_W       (8)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rstn  (sys_rstn),
        .init_done (init_done),
        .soft_req  (soft_req),
        .dom_rstn  (dom_rstn),
        .soft_ack  (soft_ack),
        .seq_busy  (seq_busy),
        .all_ready (all_ready)
    );

    typedef struct {
        int         cyc;
        logic [9:0] val;   // {dom_rstn, soft_ack, seq_busy, all_ready}
    } exp_t;

    localparam logic [9:0] RST_VAL = {4'b0000, 4'b0000, 1'b1, 1'b0};

    exp_t       sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc;
    logic [9:0] prev_val;
    logic [9:0] cur_val;
    logic       drain_req = 1'b0;
    logic       drain_ack = 1'b0;

    // 10-unit system clock.
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Edge counter: value seen at a negedge is the number of the last posedge.
    always @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    function automatic void expect_ev(input int c, input logic [3:0] d,
                                      input logic [3:0] a, input logic b,
                                      input logic r);
        exp_t e;
        e.cyc = c;
        e.val = {d, a, b, r};
        sb.push_back(e);
    endfunction

    // Monitor: reset-state checks while reset is low, else compare on change.
    always @(negedge sys_clk) begin
        cur_val = {dom_rstn, soft_ack, seq_busy, all_ready};
        if (!sys_rstn) begin
            vectors++;
            if (cur_val !== RST_VAL) begin
                miscompares++;
                $display("FAIL reset_state t=%0t got=%b want=%b", $time, cur_val, RST_VAL);
            end
            prev_val = RST_VAL;
        end else begin
            if (cur_val !== prev_val) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change edge=%0d got=%b (no change expected)", cyc, cur_val);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.val !== cur_val) begin
                        miscompares++;
                        $display("FAIL output_change got edge=%0d val=%b want edge=%0d val=%b",
                                 cyc, cur_val, e.cyc, e.val);
                    end
                end
                prev_val = cur_val;
            end
            if (drain_req && !drain_ack) begin
                while (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    vectors++;
                    miscompares++;
                    $display("FAIL missing_change got none want edge=%0d val=%b", e.cyc, e.val);
                end
                drain_ack = 1'b1;
            end
        end
    end

    // Wait until the negedge just before edge n, so edge n samples what is driven.
    task automatic before_edge(input int n);
        while (cyc < n - 1) @(negedge sys_clk);
    endtask

    task automatic pulse_req(input int n, input logic [3:0] r);
        before_edge(n);
        soft_req = r;
        @(negedge sys_clk);
        soft_req = '0;
    endtask

    task automatic set_init(input int n, input logic v);
        before_edge(n);
        init_done = v;
    endtask

    // Hard bound on total run time.
    initial begin
        #20000;
        $display("FAIL watchdog timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    // Directed stimulus with hand-computed expected output changes.
    initial begin
        sys_rstn  = 1'b0;
        init_done = 1'b0;
        soft_req  = '0;
        prev_val  = RST_VAL;
        repeat (4) @(negedge sys_clk);
        sys_rstn = 1'b1;

        // Start-up: init_done sampled at edge 10, releases every 16 edges.
        expect_ev(26, 4'b0001, 4'b0000, 1'b1, 1'b0);
        expect_ev(42, 4'b0011, 4'b0000, 1'b1, 1'b0);
        expect_ev(58, 4'b0111, 4'b0000, 1'b1, 1'b0);
        expect_ev(74, 4'b1111, 4'b0000, 1'b0, 1'b1);
        set_init(10, 1'b1);

        // Single soft reset of domain 2.
        expect_ev(101, 4'b1011, 4'b0000, 1'b1, 1'b0);
        expect_ev(133, 4'b1111, 4'b0100, 1'b0, 1'b1);
        expect_ev(134, 4'b1111, 4'b0000, 1'b0, 1'b1);
        pulse_req(100, 4'b0100);

        // Two requests at once: domain 1 then domain 3, busy held throughout.
        expect_ev(151, 4'b1101, 4'b0000, 1'b1, 1'b0);
        expect_ev(183, 4'b1111, 4'b0010, 1'b1, 1'b0);
        expect_ev(184, 4'b0111, 4'b0000, 1'b1, 1'b0);
        expect_ev(216, 4'b1111, 4'b1000, 1'b0, 1'b1);
        expect_ev(217, 4'b1111, 4'b0000, 1'b0, 1'b1);
        pulse_req(150, 4'b1010);

        // Re-request of domain 1 while it is in soft reset.
        expect_ev(251, 4'b1101, 4'b0000, 1'b1, 1'b0);
        expect_ev(283, 4'b1111, 4'b0010, 1'b1, 1'b0);
        expect_ev(284, 4'b1101, 4'b0000, 1'b1, 1'b0);
        expect_ev(316, 4'b1111, 4'b0010, 1'b0, 1'b1);
        expect_ev(317, 4'b1111, 4'b0000, 1'b0, 1'b1);
        pulse_req(250, 4'b0010);
        pulse_req(260, 4'b0010);

        // Abort mid-soft-reset of domain 2, restart; requests during
        // WAIT_INIT and GAP must be dropped.
        expect_ev(351, 4'b1011, 4'b0000, 1'b1, 1'b0);
        expect_ev(360, 4'b0000, 4'b0000, 1'b1, 1'b0);
        expect_ev(386, 4'b0001, 4'b0000, 1'b1, 1'b0);
        expect_ev(402, 4'b0011, 4'b0000, 1'b1, 1'b0);
        expect_ev(418, 4'b0111, 4'b0000, 1'b1, 1'b0);
        expect_ev(434, 4'b1111, 4'b0000, 1'b0, 1'b1);
        pulse_req(350, 4'b0100);
        set_init(360, 1'b0);
        pulse_req(365, 4'b0010);
        set_init(370, 1'b1);
        pulse_req(380, 4'b0001);
        pulse_req(390, 4'b1000);

        // Drop init from RUN and restart, then assert reset mid-GAP.
        expect_ev(500, 4'b0000, 4'b0000, 1'b1, 1'b0);
        expect_ev(526, 4'b0001, 4'b0000, 1'b1, 1'b0);
        expect_ev(542, 4'b0011, 4'b0000, 1'b1, 1'b0);
        set_init(500, 1'b0);
        set_init(510, 1'b1);

        before_edge(549);
        drain_req = 1'b1;
        for (int k = 0; k < 10 && !drain_ack; k++) @(negedge sys_clk);
        if (!drain_ack) begin
            $display("FAIL drain_timeout got no ack want ack");
            $fatal(1, "drain timeout");
        end

        // Asynchronous reset between clock edges; the next negedge precedes
        // any posedge, so outputs must already be at reset values.
        while (cyc < 550) @(posedge sys_clk);
        #2;
        sys_rstn = 1'b0;
        repeat (2) @(negedge sys_clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crg_rst_sequencer.md
Name: crg_rst_sequencer

Overview:
- Reset-release controller in the FPGA clock/reset generation area. Runs on the system clock.
- Takes the synchronized system reset and a platform-ready indication, then releases peripheral reset domains (DDR, UART, QSPI, SD, ...) one at a time in fixed order with programmable spacing.
- After start-up, services per-domain soft-reset requests. Each request re-asserts one domain's reset for a fixed hold time, then acknowledges.
- Outputs feed the per-domain reset synchronizers of the destination clock domains.

Parameters:
- NUM_DOM, 4: number of sequenced reset domains. Index 0 is released first.
- GAP_CYCLES, 16: sys_clk cycles between successive domain releases at start-up. Must be at least 1.
- HOLD_CYCLES, 32: sys_clk cycles a domain is held in reset for a soft reset. Must be at least 1.
- CNT_W, 8: counter width. Must satisfy 2^CNT_W > max(GAP_CYCLES, HOLD_CYCLES).

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rstn  in  1  asynchronous active-low reset.
- init_done  in  1  platform ready (clock lock / DDR calibration). Already synchronous to sys_clk.
- soft_req  in  NUM_DOM  one-cycle pulse per domain requesting a soft reset.
- dom_rstn  out  NUM_DOM  per-domain active-low reset. Registered.
- soft_ack  out  NUM_DOM  one-cycle pulse when a soft reset of that domain completes.
- seq_busy  out  1  high while sequencing or servicing a soft reset.
- all_ready  out  1  high when every domain is out of reset and the block is idle.

Behaviour:
- Reset is asynchronous and active-low; one clock (sys_clk).
- While sys_rstn=0:
  - dom_rstn=0, soft_ack=0, seq_busy=1, all_ready=0.
  - pending=0, counter=0, idx=0, state=WAIT_INIT.
- All outputs are driven from flops. No combinational path from any input to any output.
- States: WAIT_INIT, GAP, RUN, SOFT.
- WAIT_INIT:
  - Remain here while init_done=0.
  - On the first edge with init_done=1: go to GAP with idx=0 and counter=0.
- GAP:
  - Counter increments each cycle.
  - On the edge where counter==GAP_CYCLES-1: set dom_rstn[idx]=1 and clear counter.
  - If idx==NUM_DOM-1, go to RUN; otherwise increment idx and stay in GAP.
  - Result: domain k rises GAP_CYCLES*(k+1) edges after the edge that sampled init_done=1.
- RUN:
  - seq_busy=0; all_ready=1.
  - If pending is nonzero: select the lowest set index i (fixed priority) and go to SOFT.
  - On that same edge: dom_rstn[i]=0, pending[i] cleared, counter=0.
  - all_ready and seq_busy reflect the SOFT state from the next edge on.
- SOFT:
  - Counter increments each cycle.
  - On the edge where counter==HOLD_CYCLES-1: set dom_rstn[i]=1 and soft_ack[i]=1 (for exactly one cycle), then go to RUN.
  - dom_rstn[i] is therefore low for exactly HOLD_CYCLES cycles.
  - Only one domain is in soft reset at a time.
- Request capture (pending register):
  - A soft_req[j] pulse sets pending[j] in RUN and SOFT only.
  - Pulses during WAIT_INIT or GAP are dropped, because the domain is already in reset.
  - Pulses on several domains in the same cycle are all captured and serviced lowest-index first, back-to-back. RUN is occupied for one cycle between services.
  - A pulse for the domain currently in SOFT sets its pending bit again, and that domain is serviced again afterwards.
  - If a pulse and the pending clear for the same bit land on the same edge, set wins.
- init_done falling while in GAP, RUN or SOFT, on the next edge:
  - All dom_rstn=0, pending cleared, soft_ack=0, counter=0, state=WAIT_INIT.
  - No ack is issued for an aborted soft reset.
- Counter never wraps: it is cleared on every state transition.

Test Plan:
- NUM_DOM=4, GAP=16, HOLD=32. Release sys_rstn, raise init_done at edge 10 → dom_rstn[0..3] rise at edges 26, 42, 58, 74; all_ready=1 from edge 74 onward; seq_busy falls at edge 74.
- In RUN, pulse soft_req=4'b0100 at edge 100 → dom_rstn[2]=0 over edges 101..132, rises at edge 133 with soft_ack[2]=1 for one cycle; all_ready=0 over 101..132; other domains stay 1.
- In RUN, pulse soft_req=4'b1010 in one cycle → domain 1 serviced first with its ack, one RUN cycle, then domain 3 with its ack; total 2×32+1 cycles of seq_busy.
- Pulse soft_req[1] while domain 1 is in SOFT → two consecutive acks for domain 1, second hold fully 32 cycles.
- Pulse soft_req[0] during GAP → no soft reset and no ack after RUN is reached.
- Drop init_done mid-SOFT on domain 2 → all dom_rstn=0 next edge, no soft_ack; re-raising init_done repeats the full start-up sequence. Assert sys_rstn mid-GAP → all outputs at reset values immediately, without waiting for a clock edge.
